// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - operation encodings carried on the op bus (MULT/MULTU/DIV/DIVU)
//   - sequencer state encodings (IDLE/ITER/FIX)
//   - small decode helpers for the op field
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    typedef logic [1:0] md_op_t;

    localparam md_op_t MULT_OP  = 2'b00;
    localparam md_op_t MULTU_OP = 2'b01;
    localparam md_op_t DIV_OP   = 2'b10;
    localparam md_op_t DIVU_OP  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // op[1] selects divide, op[0] selects the unsigned variant.
    function automatic logic op_is_div(input md_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// EX-stage <-> multiply/divide unit connection.
//   master (pipeline side): drives start/op/din0/din1, flush, hilo_rd,
//                           mthi/mtlo/wdata; observes hi/lo/busy/done/stall
//   slave  (unit side):     the reverse
// -----------------------------------------------------------------------------
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             start;
    md_op_t           op;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic             flush;
    logic             hilo_rd;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, din0, din1, flush, hilo_rd, mthi, mtlo, wdata,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, din0, din1, flush, hilo_rd, mthi, mtlo, wdata,
        output hi, lo, busy, done, stall
    );

endinterface

// File: rtl/muldiv_unit_step.sv
// -----------------------------------------------------------------------------
// muldiv_unit_step
// Combinational single iteration of the multiply/divide datapath.
//   is_div   in   1        0: shift-add multiply step, 1: restoring divide step
//   acc      in   2*WIDTH  current accumulator
//   opnd     in   WIDTH    multiplicand (multiply) or divisor (divide)
//   acc_next out  2*WIDTH  accumulator after this iteration
// Multiply: acc = {partial product high, remaining multiplier bits}; the LSB
//   decides whether opnd is added, then everything shifts right by one.
// Divide:   acc = {remainder, dividend bits / quotient bits}; shift left by
//   one, trial-subtract the divisor, and the new quotient bit enters the LSB.
// -----------------------------------------------------------------------------
module muldiv_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    always_comb begin
        // Carry out of the add becomes the new MSB after the right shift.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

        // Remainder shifted left with the next dividend bit; it can briefly
        // need WIDTH+1 bits before the trial subtraction.
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd});
        // After a successful subtraction the remainder is below the divisor,
        // so it always fits back into WIDTH bits.
        div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd}) : div_shift[WIDTH-1:0];

        if (is_div) begin
            acc_next = {div_rem, acc[WIDTH-2:0], div_ge};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU sequencer next to the EX-stage ALU. Owns the
// HI/LO registers, stalls the pipeline on HI/LO hazards and aborts on flush.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous, active-high reset
//   bus   muldiv_unit_if.slave:
//           start/op/din0/din1  operation request (din0 = rs, din1 = rt)
//           flush               abort any operation, block same-cycle writes
//           hilo_rd             MFHI/MFLO in EX (stalls while busy)
//           mthi/mtlo/wdata     direct HI/LO writes (IDLE only)
//           hi/lo               HI/LO registers
//           busy                operation in progress (registered)
//           done                one-cycle pulse after an operation wrote HI/LO
//           stall               busy & (start | hilo_rd | mthi | mtlo)
// Timing: start accepted at edge N, WIDTH iterations at edges N+1..N+WIDTH,
// sign fix-up and HI/LO write at edge N+WIDTH+1.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);

    logic [1:0]         state_reg,  state_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic [2*WIDTH-1:0] acc_reg,    acc_next;
    logic [WIDTH-1:0]   opnd_reg,   opnd_next;
    logic               is_div_reg, is_div_next;
    logic               neg_q_reg,  neg_q_next;
    logic               neg_r_reg,  neg_r_next;
    logic [WIDTH-1:0]   hi_reg,     hi_next;
    logic [WIDTH-1:0]   lo_reg,     lo_next;
    logic               busy_reg,   busy_next;
    logic               done_reg,   done_next;

    logic [2*WIDTH-1:0] step_acc;
    logic               sign0;
    logic               sign1;
    logic [WIDTH-1:0]   mag0;
    logic [WIDTH-1:0]   mag1;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    muldiv_unit_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .is_div   (is_div_reg),
        .acc      (acc_reg),
        .opnd     (opnd_reg),
        .acc_next (step_acc)
    );

    always_comb begin
        // Operand magnitudes. Read as unsigned WIDTH-bit values, negating
        // -2**(WIDTH-1) yields exactly 2**(WIDTH-1), so no precision is lost.
        sign0 = op_is_signed(bus.op) & bus.din0[WIDTH-1];
        sign1 = op_is_signed(bus.op) & bus.din1[WIDTH-1];
        mag0  = sign0 ? -bus.din0 : bus.din0;
        mag1  = sign1 ? -bus.din1 : bus.din1;

        // Sign fix-up of the finished magnitude result.
        prod_fix = neg_q_reg ? -acc_reg : acc_reg;
        quo      = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem      = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        opnd_next   = opnd_reg;
        is_div_next = is_div_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;

        if (bus.flush) begin
            // Flush wins over everything: abandon the operation and drop any
            // same-cycle start or MTHI/MTLO. HI/LO keep their old contents.
            state_next = ST_IDLE;
            cnt_next   = '0;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // A write alongside start still lands; the result
                    // overwrites it when the operation finishes.
                    if (bus.mthi) hi_next = bus.wdata;
                    if (bus.mtlo) lo_next = bus.wdata;
                    if (bus.start) begin
                        is_div_next = op_is_div(bus.op);
                        neg_q_next  = sign0 ^ sign1;
                        neg_r_next  = sign0;
                        if (op_is_div(bus.op)) begin
                            acc_next  = {{WIDTH{1'b0}}, mag0};
                            opnd_next = mag1;
                        end else begin
                            // Multiplier bits sit in the low half and are
                            // consumed LSB first.
                            acc_next  = {{WIDTH{1'b0}}, mag1};
                            opnd_next = mag0;
                        end
                        cnt_next   = '0;
                        busy_next  = 1'b1;
                        state_next = ST_ITER;
                    end
                end
                ST_ITER: begin
                    acc_next = step_acc;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_next = ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (is_div_reg) begin
                        // A zero divisor leaves the dividend magnitude as the
                        // remainder; re-applying the dividend sign restores
                        // the original din0 in HI. LO is forced to all ones.
                        lo_next = (opnd_reg == '0) ? {WIDTH{1'b1}} : quo;
                        hi_next = rem;
                    end else begin
                        hi_next = prod_fix[2*WIDTH-1:WIDTH];
                        lo_next = prod_fix[WIDTH-1:0];
                    end
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            opnd_reg   <= opnd_next;
            is_div_reg <= is_div_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.stall = busy_reg & (bus.start | bus.hilo_rd | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit. A behavioural model (plain arithmetic plus a
// busy countdown) predicts hi/lo/busy/done/stall and is compared on every
// falling edge; directed tests also check hand-computed literal results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic rst;
    logic cmp_en = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        if (op == MULT_OP) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return 64'(sp);
        end
        if (op == MULTU_OP) begin
            up = {32'd0, a} * {32'd0, b};
            return up;
        end
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (op == DIV_OP) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
            sa = $signed(a);
            sb = $signed(b);
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_busy;
    logic        m_done;
    int          m_left;
    logic [63:0] m_res;

    always @(posedge clk) begin
        if (rst) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (bus.flush) begin
                m_busy <= 1'b0;
                m_left <= 0;
            end else if (m_busy) begin
                if (m_left == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
                m_left <= m_left - 1;
            end else begin
                if (bus.mthi) m_hi <= bus.wdata;
                if (bus.mtlo) m_lo <= bus.wdata;
                if (bus.start) begin
                    m_busy <= 1'b1;
                    m_left <= LAT;
                    m_res  <= ref_result(bus.op, bus.din0, bus.din1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_hi",    64'(bus.hi),   64'(m_hi));
            chk("cyc_lo",    64'(bus.lo),   64'(m_lo));
            chk("cyc_busy",  64'(bus.busy), 64'(m_busy));
            chk("cyc_done",  64'(bus.done), 64'(m_done));
            chk("cyc_stall", 64'(bus.stall),
                64'(m_busy & (bus.start | bus.hilo_rd | bus.mthi | bus.mtlo)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_in();
        bus.start   = 1'b0;
        bus.op      = MULT_OP;
        bus.din0    = '0;
        bus.din1    = '0;
        bus.flush   = 1'b0;
        bus.hilo_rd = 1'b0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.wdata   = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.din0  = a;
        bus.din1  = b;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        int guard;
        guard       = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && guard < 100) begin
            if (bus.busy === 1'b1) busy_cycles++;
            tick(1);
            guard++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c;
        issue(op, a, b);
        wait_done(c);
        $display("op=%0d din0=%h din1=%h -> hi=%h lo=%h busy_cycles=%0d",
                 op, a, b, bus.hi, bus.lo, c);
        chk({name, "_cycles"}, 64'(c), 64'(LAT));
        chk({name, "_done"},   64'(bus.done), 64'(1));
        chk({name, "_hi"},     64'(bus.hi), 64'(exp_hi));
        chk({name, "_lo"},     64'(bus.lo), 64'(exp_lo));
        tick(1);
        chk({name, "_done_pulse"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n_done;
        idle_in();
        rst = 1'b1;
        tick(1);
        cmp_en = 1'b1;
        tick(1);
        rst = 1'b0;

        // Reset state; hilo_rd while idle must not stall.
        chk("rst_hi",   64'(bus.hi),   64'(0));
        chk("rst_lo",   64'(bus.lo),   64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        bus.hilo_rd = 1'b1;
        #1;
        chk("rst_stall", 64'(bus.stall), 64'(0));
        bus.hilo_rd = 1'b0;
        tick(1);

        // Arithmetic vectors.
        run_op("mult_m3x7",   MULT_OP,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_max",   MULTU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_minsq",  MULT_OP,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("multu_shift", MULTU_OP, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
        run_op("div_m7d2",    DIV_OP,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7dm2",    DIV_OP,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("div_100d7",   DIV_OP,   32'd100,      32'd7,        32'h00000002, 32'h0000000E);
        run_op("divu_7d0",    DIVU_OP,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
        run_op("div_m5d0",    DIV_OP,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div_ovf",     DIV_OP,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divu_max3",   DIVU_OP,  32'hFFFFFFFF, 32'd3,        32'h00000000, 32'h55555555);

        // HI/LO read hazard plus a second start held while busy.
        issue(MULT_OP, 32'd5, 32'd6);
        bus.hilo_rd = 1'b1;
        bus.start   = 1'b1;
        bus.op      = MULTU_OP;
        bus.din0    = 32'd3;
        bus.din1    = 32'd4;
        #1;
        chk("haz_stall_busy", 64'(bus.stall), 64'(1));
        wait_done(c);
        chk("haz_done_stall", 64'(bus.stall), 64'(0));
        chk("haz_done_lo",    64'(bus.lo),    64'(30));
        tick(1);
        bus.start   = 1'b0;
        bus.hilo_rd = 1'b0;
        chk("haz_second_busy", 64'(bus.busy), 64'(1));
        wait_done(c);
        $display("op=%0d din0=%h din1=%h -> hi=%h lo=%h busy_cycles=%0d",
                 MULTU_OP, 32'd3, 32'd4, bus.hi, bus.lo, c);
        chk("haz_second_cycles", 64'(c),      64'(LAT));
        chk("haz_second_lo",     64'(bus.lo), 64'(12));
        tick(1);

        // MTHI/MTLO in idle, then flush at iteration 10.
        bus.mthi  = 1'b1;
        bus.wdata = 32'h0000CAFE;
        tick(1);
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h00001234;
        tick(1);
        bus.mtlo  = 1'b0;
        chk("mthi_hi", 64'(bus.hi), 64'(32'h0000CAFE));
        chk("mtlo_lo", 64'(bus.lo), 64'(32'h00001234));
        issue(MULT_OP, 32'd100, 32'd200);
        tick(9);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'(0));
        chk("flush_done", 64'(bus.done), 64'(0));
        chk("flush_lo",   64'(bus.lo),   64'(32'h00001234));
        chk("flush_hi",   64'(bus.hi),   64'(32'h0000CAFE));
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) n_done++;
            tick(1);
        end
        chk("flush_no_done", 64'(n_done), 64'(0));
        $display("flush at iteration 10: hi=%h lo=%h", bus.hi, bus.lo);

        // Flush beats start and mtlo in the same idle cycle.
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = MULT_OP;
        bus.din0  = 32'd2;
        bus.din1  = 32'd2;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h00005555;
        tick(1);
        idle_in();
        chk("flush_start_busy", 64'(bus.busy), 64'(0));
        chk("flush_mtlo_lo",    64'(bus.lo),   64'(32'h00001234));
        $display("flush+start+mtlo: busy=%0d lo=%h", bus.busy, bus.lo);

        // Flush arriving during the fix-up cycle: no HI/LO write, no done.
        issue(MULT_OP, 32'd2, 32'd3);
        tick(W);
        chk("fix_still_busy", 64'(bus.busy), 64'(1));
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        chk("fixflush_busy", 64'(bus.busy), 64'(0));
        chk("fixflush_done", 64'(bus.done), 64'(0));
        chk("fixflush_hi",   64'(bus.hi),   64'(32'h0000CAFE));
        chk("fixflush_lo",   64'(bus.lo),   64'(32'h00001234));
        $display("flush in fix cycle: hi=%h lo=%h", bus.hi, bus.lo);
        tick(3);

        // Reset in the middle of an iteration clears HI/LO.
        issue(DIVU_OP, 32'd1000, 32'd7);
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_hi",   64'(bus.hi),   64'(0));
        chk("midrst_lo",   64'(bus.lo),   64'(0));
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_done", 64'(bus.done), 64'(0));
        $display("reset mid-iteration: hi=%h lo=%h busy=%0d", bus.hi, bus.lo, bus.busy);

        // MTHI together with start: write lands, product overwrites it.
        bus.mthi  = 1'b1;
        bus.wdata = 32'h0000DEAD;
        issue(MULT_OP, 32'hFFFFFFFD, 32'd7);
        bus.mthi  = 1'b0;
        chk("mthi_start_hi_now", 64'(bus.hi), 64'(32'h0000DEAD));
        wait_done(c);
        $display("op=%0d din0=%h din1=%h -> hi=%h lo=%h busy_cycles=%0d",
                 MULT_OP, 32'hFFFFFFFD, 32'd7, bus.hi, bus.lo, c);
        chk("mthi_start_cycles", 64'(c),      64'(LAT));
        chk("mthi_start_hi",     64'(bus.hi), 64'(32'hFFFFFFFF));
        chk("mthi_start_lo",     64'(bus.lo), 64'(32'hFFFFFFEB));
        tick(2);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
